pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Consumes the next-PC candidates produced by the PC incrementer: the PC+4 and PC+Imm values, plus the JALR target from the ALU.
- Owns the architectural PC register and runs the instruction-memory request/response handshake.
- Presents one fetched instruction at a time to decode, together with its PC.
- Sits between instruction memory and decode in the single-cycle core. It also feeds PC back to the incrementer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and the first fetch address.
- XLEN, 32, address and instruction width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- PC_4  in  XLEN  sequential next PC, PC+4.
- PC_Imm  in  XLEN  branch/JAL target, PC+Imm.
- ALU_Out  in  XLEN  JALR target, before masking.
- PC_Sel  in  2  next-PC select: 00 = PC_4, 01 = PC_Imm, 10 = ALU_Out & ~1, 11 = reserved (treated as 00).
- Instr_Ack  in  1  decode has consumed the current instruction; PC_Sel is valid this cycle.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  XLEN  fetch address, equal to PC.
- IMem_Gnt  in  1  memory accepted the request.
- IMem_Rvalid  in  1  read data valid.
- IMem_Rdata  in  XLEN  read data.
- PC  out  XLEN  architectural PC.
- Instr  out  XLEN  held instruction.
- Instr_Valid  out  1  Instr/PC pair valid for decode.
- Fetch_Misalign  out  1  misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (RSTN low, asynchronous):
  - PC=RESET_PC, state=FETCH.
  - IMem_Req=0, Instr=0, Instr_Valid=0, Fetch_Misalign=0.
  - On the first rising CLK edge after RSTN deasserts: IMem_Req=1.
- States: FETCH, WAIT_R, HOLD. All transitions occur on the rising CLK edge.
- FETCH:
  - IMem_Req=1 and IMem_Addr=PC, held stable until IMem_Gnt.
  - Gnt=1 -> WAIT_R and IMem_Req drops.
  - Gnt=1 with Rvalid=1 in the same cycle (zero-latency memory): capture Rdata -> HOLD directly.
- WAIT_R: IMem_Req=0. On Rvalid=1, Instr<=IMem_Rdata and Instr_Valid<=1 -> HOLD.
- HOLD:
  - Instr and PC are held stable.
  - On Instr_Ack=1: PC<=selected target, Instr_Valid<=0 -> FETCH.
- Latency: Instr_Ack to the next IMem_Req is 1 cycle. Ack to Instr_Valid is 3 cycles minimum with 1-cycle memory, or 2 cycles with a same-cycle Gnt+Rvalid.
- Instr_Ack outside HOLD is ignored. PC never changes outside the HOLD->FETCH transition.
- IMem_Rvalid outside WAIT_R (or outside the FETCH+Gnt case) is ignored; no data is captured.
- JALR target: bit 0 forced to 0. No other masking.
- Arithmetic: none internal. Targets are taken modulo 2^XLEN, so wrap from 32'hFFFF_FFFC via PC_4 gives 0.
- Reset mid-handshake: immediate return to reset values. Any outstanding memory response is discarded because the state is FETCH, not WAIT_R.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_TRAP_EN.
- With the macro:
  - In HOLD on Instr_Ack, if the selected target[1:0] != 0: PC still loads the target, Fetch_Misalign<=1, state -> HOLD_TRAP (fourth state).
  - HOLD_TRAP: no request issued, Instr_Valid=0. Cleared only by reset.
- Without the macro: Fetch_Misalign tied to 0 and the target is fetched as-is.

Decomposition:
- Shared core package:
  - pc_sel_t enum (PC_SEL_SEQ, PC_SEL_BR, PC_SEL_JALR, PC_SEL_RSVD).
  - fetch_state_t enum.
  - RESET_PC default constant.
- Sub-module: pc_next_mux, combinational target selection and JALR masking. The FSM and registers stay in the top.

Test Plan:
1. Reset release, memory Gnt after 1 cycle, Rvalid 1 cycle later with 32'h00500093 -> IMem_Addr=0, Instr=32'h00500093, Instr_Valid=1, PC=0.
2. Ack with PC_Sel=00, PC_4=4 -> next IMem_Addr=4. Then Ack with PC_Sel=01, PC_Imm=32'h100 -> IMem_Addr=32'h100.
3. PC_Sel=10, ALU_Out=32'h0000_0203 -> PC=32'h0000_0202. Without macro, fetch at 0x202 and Fetch_Misalign=0. With macro, Fetch_Misalign=1 and no IMem_Req.
4. Gnt held low 5 cycles -> IMem_Req and IMem_Addr stable throughout. Same-cycle Gnt+Rvalid -> HOLD in one cycle.
5. RSTN low while in WAIT_R, then Rvalid pulses during reset and the cycle after -> Instr=0, Instr_Valid=0, PC=RESET_PC, fresh request issued.
6. PC_4=0 at PC=32'hFFFF_FFFC with PC_Sel=11 -> PC wraps to 0 and reserved select behaves as sequential.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
//   Shared types and defaults for the fetch controller and its next-PC mux.
//   Contents:
//     XLEN_DEFAULT      - default address/instruction width
//     RESET_PC_DEFAULT  - default PC loaded on reset (first fetch address)
//     pc_sel_t          - encoding of the PC_Sel next-PC select input
//     fetch_state_t     - fetch FSM state encoding (HOLD_TRAP is only
//                         reachable when PC_FETCH_MISALIGN_TRAP_EN is defined)
// ----------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEL_SEQ  = 2'b00,  // PC + 4
        PC_SEL_BR   = 2'b01,  // PC + Imm (branch / JAL)
        PC_SEL_JALR = 2'b10,  // ALU result with bit 0 cleared
        PC_SEL_RSVD = 2'b11   // reserved, behaves as sequential
    } pc_sel_t;

    typedef enum logic [1:0] {
        FETCH     = 2'b00,
        WAIT_R    = 2'b01,
        HOLD      = 2'b10,
        HOLD_TRAP = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
//   Combinational next-PC selection.
//   Ports:
//     pc_sel   in   2     select (see pc_sel_t); reserved code = sequential
//     pc_4     in   XLEN  sequential next PC
//     pc_imm   in   XLEN  branch / JAL target
//     alu_out  in   XLEN  JALR target before masking
//     next_pc  out  XLEN  selected target
// ----------------------------------------------------------------------------
module pc_next_mux
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] pc_4,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] next_pc
);

    pc_sel_t sel;
    assign sel = pc_sel_t'(pc_sel);

    always_comb begin
        next_pc = pc_4;
        case (sel)
            PC_SEL_BR:   next_pc = pc_imm;
            // JALR clears only bit 0; bit 1 is left alone so a half-word
            // aligned target is still visible to the misalign check.
            PC_SEL_JALR: next_pc = {alu_out[XLEN-1:1], 1'b0};
            default:     next_pc = pc_4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Owns the architectural PC, runs the instruction-memory request/response
//   handshake and presents one fetched instruction at a time to decode.
//
//   Build option: define PC_FETCH_MISALIGN_TRAP_EN to stop fetching when a
//   selected target is not word aligned (Fetch_Misalign set, state HOLD_TRAP,
//   cleared only by reset). Without it Fetch_Misalign is constant 0 and the
//   target is fetched as-is.
//
//   Ports:
//     CLK, RSTN       clock (rising edge), asynchronous active-low reset
//     PC_4, PC_Imm    next-PC candidates from the incrementer
//     ALU_Out         JALR target before bit-0 masking
//     PC_Sel          next-PC select (00 seq, 01 br, 10 jalr, 11 = seq)
//     Instr_Ack       decode consumed Instr; PC_Sel valid this cycle
//     IMem_Req/Addr   fetch request and address (Addr == PC)
//     IMem_Gnt        memory accepted the request
//     IMem_Rvalid/Rdata  read response
//     PC, Instr, Instr_Valid  instruction/PC pair for decode
//     Fetch_Misalign  misaligned-target flag
//     dbg_state       current FSM state, for observation only
//
//   Handshake rules: a request transfers on a rising edge where IMem_Req and
//   IMem_Gnt are both 1; IMem_Addr is held stable from the first cycle of
//   IMem_Req until that edge. A response is taken only on a rising edge where
//   IMem_Rvalid is 1 and the controller is waiting for it (WAIT_R, or the
//   granting edge itself); any other Rvalid is dropped. Toward decode,
//   Instr_Valid is the valid and Instr_Ack the ready: the pair transfers on
//   an edge with both high, and Instr/PC hold until then.
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [XLEN-1:0] PC_4,
    input  logic [XLEN-1:0] PC_Imm,
    input  logic [XLEN-1:0] ALU_Out,
    input  logic [1:0]      PC_Sel,
    input  logic            Instr_Ack,
    output logic            IMem_Req,
    output logic [XLEN-1:0] IMem_Addr,
    input  logic            IMem_Gnt,
    input  logic            IMem_Rvalid,
    input  logic [XLEN-1:0] IMem_Rdata,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instr,
    output logic            Instr_Valid,
    output logic            Fetch_Misalign,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            req_q;
    logic            valid_q;
    logic [XLEN-1:0] next_pc;

    pc_next_mux #(
        .XLEN    (XLEN)
    ) u_next_mux (
        .pc_sel  (PC_Sel),
        .pc_4    (PC_4),
        .pc_imm  (PC_Imm),
        .alu_out (ALU_Out),
        .next_pc (next_pc)
    );

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // Out of reset the request is not yet raised; raise it on
                    // the first edge. Gnt is only meaningful while Req is up.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (IMem_Gnt) begin
                        req_q <= 1'b0;
                        if (IMem_Rvalid) begin
                            instr_q <= IMem_Rdata;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            state   <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (IMem_Rvalid) begin
                        instr_q <= IMem_Rdata;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (Instr_Ack) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state      <= HOLD_TRAP;
                        end else begin
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
`else
                        // Request goes out on the very next cycle.
                        req_q <= 1'b1;
                        state <= FETCH;
`endif
                    end
                end
                HOLD_TRAP: begin
                    // Terminal until reset: no request, nothing valid.
                    state <= HOLD_TRAP;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign IMem_Req    = req_q;
    assign IMem_Addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Instr_Valid = valid_q;
    assign dbg_state   = state;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    assign Fetch_Misalign = misalign_q;
`else
    assign Fetch_Misalign = 1'b0;
`endif

endmodule
